ctrl_set_gen: RTL and testbench

- Upstream stimulus stage for the control-set flop bank (sync set/reset plus clock-enable flops) used in fabric bring-up.
- Generates the 4-bit data, clock-enable and synchronous-reset streams the flop bank consumes.
- On a start pulse it initialises the downstream flops, runs a deterministic LFSR-driven burst, then signals completion.
- All outputs are registered; the downstream stage samples them on the same clk.

---
 rtl/ctrl_set_gen_pkg.sv | 27 ++
 rtl/ctrl_set_gen_lfsr8.sv | 39 +++
 rtl/ctrl_set_gen.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_set_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_set_gen_pkg.sv
// rtl/ctrl_set_gen_pkg.sv - shared types and constants for the control-set stimulus generator
package ctrl_set_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Length of the clearing phase that precedes every burst.
  localparam int INIT_CYCLES = 2;

  // Feedback taps at bits 7,5,4,3 give the maximal 255-state sequence.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One left shift of the Fibonacci LFSR; the feedback enters at bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Counter width for a modulo-n counter; at least one bit so n=1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_set_gen_lfsr8.sv
// rtl/ctrl_set_gen_lfsr8.sv - 8-bit Fibonacci LFSR with synchronous reload and advance enable
module lfsr8
  import ctrl_set_gen_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Next value: a reload takes priority over an advance.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = lfsr_step(state_q);
    end
  end

  // State register; reset lands on the same value a reload would give.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ctrl_set_gen.sv
// rtl/ctrl_set_gen.sv - start/init/burst/done stimulus sequencer for the control-set flop bank
module ctrl_set_gen
  import ctrl_set_gen_pkg::*;
#(
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         SR_PERIOD = 16,
  parameter int         CE_ON     = 3,
  parameter int         CE_OFF    = 1,
  parameter int         BURST_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] d,
  output logic       ce,
  output logic       sr,
  output logic       busy,
  output logic       done
);

  localparam int CE_PERIOD = CE_ON + CE_OFF;
  localparam int BEAT_W    = cnt_width(BURST_LEN);
  localparam int CE_W      = cnt_width(CE_PERIOD);
  localparam int SR_W      = cnt_width(SR_PERIOD);
  localparam int INIT_W    = cnt_width(INIT_CYCLES);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_PERIOD - 1);
  localparam logic [SR_W-1:0]   SR_LAST   = SR_W'(SR_PERIOD - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  // One extra bit so CE_ON == CE_PERIOD (no off time) still fits.
  localparam logic [CE_W:0]     CE_ON_V   = (CE_W + 1)'(CE_ON);

  state_e              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CE_W-1:0]     ce_cnt_q, ce_cnt_d;
  logic [SR_W-1:0]     sr_cnt_q, sr_cnt_d;

  logic [3:0]          d_q, d_d;
  logic                ce_q, ce_d;
  logic                sr_q, sr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [7:0]          lfsr_state;
  logic                lfsr_load;
  logic                lfsr_en;
  logic                lfsr_unused;

  // The LFSR always holds the value for the beat about to be presented, so
  // it is reloaded throughout INIT and steps on each edge that enters a beat.
  assign lfsr_load   = (state_d == INIT);
  assign lfsr_en     = (state_d == RUN);
  assign lfsr_unused = ^lfsr_state[7:4];

  lfsr8 #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .seed  (SEED),
    .state (lfsr_state)
  );

  // Next state and beat bookkeeping; ce/sr phase counters track the beat index modulo their periods.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    beat_d     = beat_q;
    ce_cnt_d   = ce_cnt_q;
    sr_cnt_d   = sr_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = INIT;
          init_cnt_d = '0;
          beat_d     = '0;
          ce_cnt_d   = '0;
          sr_cnt_d   = '0;
        end
      end
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (stop || (beat_q == BEAT_LAST)) begin
          state_d = DONE;
        end else begin
          beat_d   = beat_q + 1'b1;
          ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
          sr_cnt_d = (sr_cnt_q == SR_LAST) ? '0 : sr_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so the registered outputs line up with the state.
  always_comb begin
    d_d    = d_q;
    ce_d   = 1'b0;
    sr_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      INIT: begin
        d_d    = '0;
        ce_d   = 1'b1;
        sr_d   = 1'b1;
        busy_d = 1'b1;
      end
      RUN: begin
        d_d    = lfsr_state[3:0];
        ce_d   = ({1'b0, ce_cnt_d} < CE_ON_V);
        sr_d   = (sr_cnt_d == SR_LAST);
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        d_d = d_q;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
      beat_q     <= '0;
      ce_cnt_q   <= '0;
      sr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      beat_q     <= beat_d;
      ce_cnt_q   <= ce_cnt_d;
      sr_cnt_q   <= sr_cnt_d;
    end
  end

  // Output registers; ce=sr=1 while in reset so the downstream bank clears on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      ce_q   <= 1'b1;
      sr_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      ce_q   <= ce_d;
      sr_q   <= sr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign d    = d_q;
  assign ce   = ce_q;
  assign sr   = sr_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ctrl_set_gen.sv
// tb/tb_ctrl_set_gen.sv - randomized self-checking bench for ctrl_set_gen against a burst-trace model
module tb_ctrl_set_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] d0, d1;
  logic       ce0, sr0, busy0, done0;
  logic       ce1, sr1, busy1, done1;

  always #5 clk = ~clk;

  ctrl_set_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .d     (d0),
    .ce    (ce0),
    .sr    (sr0),
    .busy  (busy0),
    .done  (done0)
  );

  ctrl_set_gen #(
    .SR_PERIOD (2),
    .CE_OFF    (0),
    .BURST_LEN (1)
  ) u_dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .d     (d1),
    .ce    (ce1),
    .sr    (sr1),
    .busy  (busy1),
    .done  (done1)
  );

  int n_vec;
  int n_err;
  string phase;

  // Per-instance model: a burst is a trace of positions 0..1 INIT, 2..2+len-1 RUN, 2+len DONE.
  int         m_blen  [2] = '{64, 1};
  int         m_ceon  [2] = '{3, 3};
  int         m_ceper [2] = '{4, 3};
  int         m_srper [2] = '{16, 2};
  bit         m_rst   [2];
  bit         m_act   [2];
  int         m_pos   [2];
  int         m_len   [2];
  logic [3:0] m_dh    [2];
  logic [7:0] lfsr_seq [255];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_out(input int i, output logic [3:0] ed, output logic ece,
                           output logic esr, output logic ebusy, output logic edone);
    int k;
    ed = m_dh[i]; ece = 1'b0; esr = 1'b0; ebusy = 1'b0; edone = 1'b0;
    if (m_rst[i]) begin
      ed = 4'h0; ece = 1'b1; esr = 1'b1;
    end else if (m_act[i]) begin
      if (m_pos[i] < 2) begin
        ed = 4'h0; ece = 1'b1; esr = 1'b1; ebusy = 1'b1;
      end else if (m_pos[i] < 2 + m_len[i]) begin
        k     = m_pos[i] - 2;
        ed    = lfsr_seq[k % 255][3:0];
        ece   = ((k % m_ceper[i]) < m_ceon[i]);
        esr   = ((k % m_srper[i]) == m_srper[i] - 1);
        ebusy = 1'b1;
      end else begin
        edone = 1'b1;
      end
    end
  endtask

  task automatic model_edge(input int i, input logic s, input logic p, input logic r);
    logic [3:0] ed;
    logic ece, esr, eb, edn;
    model_out(i, ed, ece, esr, eb, edn);
    m_dh[i] = ed;
    if (!r) begin
      m_rst[i] = 1'b1; m_act[i] = 1'b0; m_dh[i] = 4'h0;
    end else if (m_rst[i] || !m_act[i]) begin
      m_rst[i] = 1'b0;
      if (s) begin
        m_act[i] = 1'b1; m_pos[i] = 0; m_len[i] = m_blen[i];
      end
    end else begin
      if (p && m_pos[i] >= 2 && m_pos[i] < 2 + m_len[i]) m_len[i] = m_pos[i] - 1;
      m_pos[i]++;
      if (m_pos[i] > 2 + m_len[i]) m_act[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rst[i] = 1'b1; m_act[i] = 1'b0; m_dh[i] = 4'h0; m_pos[i] = 0; m_len[i] = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] ed;
    logic ece, esr, eb, edn;
    model_out(0, ed, ece, esr, eb, edn);
    check_val({phase, ".d"}, 32'(d0), 32'(ed));
    check_val({phase, ".ce"}, 32'(ce0), 32'(ece));
    check_val({phase, ".sr"}, 32'(sr0), 32'(esr));
    check_val({phase, ".busy"}, 32'(busy0), 32'(eb));
    check_val({phase, ".done"}, 32'(done0), 32'(edn));
    model_out(1, ed, ece, esr, eb, edn);
    check_val({phase, ".p.d"}, 32'(d1), 32'(ed));
    check_val({phase, ".p.ce"}, 32'(ce1), 32'(ece));
    check_val({phase, ".p.sr"}, 32'(sr1), 32'(esr));
    check_val({phase, ".p.busy"}, 32'(busy1), 32'(eb));
    check_val({phase, ".p.done"}, 32'(done1), 32'(edn));
  endtask

  // Drive inputs, let one edge happen, advance the model, then check away from the edge.
  task automatic cycle(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge(0, s, p, rst_n);
    model_edge(1, s, p, rst_n);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle, held across some edges, released mid-cycle.
  task automatic pulse_reset(input int hold);
    #2 rst_n = 1'b0;
    #1 model_reset();
    phase = "rst_async";
    compare_all();
    for (int j = 0; j < hold; j++) cycle(1'($urandom % 2), 1'($urandom % 2));
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int nb;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    lfsr_seq[0] = 8'hA5;
    for (int j = 1; j < 255; j++)
      lfsr_seq[j] = {lfsr_seq[j-1][6:0],
                     lfsr_seq[j-1][7] ^ lfsr_seq[j-1][5] ^ lfsr_seq[j-1][4] ^ lfsr_seq[j-1][3]};
    model_reset();

    phase = "reset";
    for (int j = 0; j < 4; j++) cycle(1'($urandom % 2), 1'($urandom % 2));
    rst_n = 1'b1;
    phase = "idle";
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    phase = "burst";
    cycle(1'b1, 1'b0);
    n  = 1;
    nb = busy0 ? 1 : 0;
    while (!done0 && n < 200) begin
      cycle(1'b0, 1'b0);
      n++;
      if (busy0) nb++;
    end
    check_val("done_cycle", 32'(n), 32'd67);
    check_val("busy_cycles", 32'(nb), 32'd66);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    phase = "stop";
    cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_val("stop_done", 32'(done0), 32'd1);
    repeat (4) cycle(1'b0, 1'b0);

    phase = "hold";
    repeat (150) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    phase = "midrst";
    cycle(1'b1, 1'b0);
    repeat (22) cycle(1'b0, 1'b0);
    pulse_reset(2);
    phase = "after_rst";
    cycle(1'b1, 1'b0);
    repeat (70) cycle(1'b0, 1'b0);

    phase = "random";
    for (int j = 0; j < 2000; j++) begin
      if ($urandom % 300 == 0) begin
        pulse_reset(1 + int'($urandom % 3));
        phase = "random";
      end else begin
        cycle(1'($urandom % 6 == 0), 1'($urandom % 20 == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
